apb_bus_master: RTL and testbench



---
 rtl/apb_bus_master.sv | 151 +++++++++++++++
 tb/tb_apb_bus_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_master.sv
// Initiator for the pixel register-file bus: bursts of 1-16 words, pipelined reads,
// and an optional write-readback check enabled by defining APB_MASTER_READBACK_EN.
`timescale 1ns/1ps

module apb_bus_master #(
  parameter int AMBA_WORD       = 24,
  parameter int AMBA_ADDR_DEPTH = 12
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_DEPTH:0]   cmd_addr,
  input  logic [3:0]                 cmd_len,
  input  logic                       wdata_valid,
  output logic                       wdata_ready,
  input  logic [AMBA_WORD-1:0]       wdata,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       busy,
  output logic                       wr_err,
  output logic [1:0]                 control,
  output logic [AMBA_ADDR_DEPTH:0]   address,
  output logic [AMBA_WORD-1:0]       WriteData,
  input  logic [AMBA_WORD-1:0]       ReadData
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] BUS_WRITE = 2'b01;
  localparam logic [1:0] BUS_READ  = 2'b10;

`ifdef APB_MASTER_READBACK_EN
  localparam logic READBACK = 1'b1;
`else
  localparam logic READBACK = 1'b0;
`endif

  logic [1:0]               state_q, state_d;
  logic [AMBA_ADDR_DEPTH:0] cur_addr_q, cur_addr_d;
  logic [4:0]               beats_q, beats_d;
  logic                     rb_pend_q, rb_pend_d;
  logic [1:0]               iss_q;      // read issued 1 / 2 cycles ago
  logic [1:0]               rbk_q;      // matching issue was a readback
  logic [AMBA_WORD-1:0]     rb_data_q;  // word the in-flight readback must return
  logic                     issue_rb;
  logic [1:0]               control_d;
  logic [AMBA_ADDR_DEPTH:0] address_d;
  logic [AMBA_WORD-1:0]     write_data_d;

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latch).
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_d      = beats_q;
    rb_pend_d    = rb_pend_q;
    issue_rb     = 1'b0;
    control_d    = BUS_IDLE;
    address_d    = address;
    write_data_d = WriteData;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cur_addr_d = cmd_addr;
          beats_d    = {1'b0, cmd_len} + 5'd1;
          state_d    = cmd_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (rb_pend_q) begin
          // readback reuses the address still held on the bus from the write cycle
          control_d = BUS_READ;
          issue_rb  = 1'b1;
          rb_pend_d = 1'b0;
        end else if (wdata_valid && wdata_ready) begin
          control_d    = BUS_WRITE;
          address_d    = cur_addr_q;
          write_data_d = wdata;
          cur_addr_d   = cur_addr_q + 1'b1;
          beats_d      = beats_q - 5'd1;
          rb_pend_d    = READBACK;
          if (beats_q == 5'd1) state_d = READBACK ? S_DRAIN : S_IDLE;
        end
      end
      S_READ: begin
        control_d  = BUS_READ;
        address_d  = cur_addr_q;
        cur_addr_d = cur_addr_q + 1'b1;
        beats_d    = beats_q - 5'd1;
        if (beats_q == 5'd1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rb_pend_q) begin
          control_d = BUS_READ;
          issue_rb  = 1'b1;
          rb_pend_d = 1'b0;
        end else if (iss_q == 2'b00) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      beats_q     <= '0;
      rb_pend_q   <= 1'b0;
      iss_q       <= '0;
      rbk_q       <= '0;
      rb_data_q   <= '0;
      control     <= BUS_IDLE;
      address     <= '0;
      WriteData   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      busy        <= 1'b0;
      wr_err      <= 1'b0;
      wdata_ready <= 1'b0;
      cmd_ready   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      beats_q     <= beats_d;
      rb_pend_q   <= rb_pend_d;
      control     <= control_d;
      address     <= address_d;
      WriteData   <= write_data_d;
      iss_q       <= {iss_q[0], control_d == BUS_READ};
      rbk_q       <= {rbk_q[0], issue_rb};
      if (issue_rb) rb_data_q <= WriteData;
      // ReadData is valid in the second cycle after issue; responses cannot stall
      rsp_valid   <= iss_q[1] && !rbk_q[1];
      if (iss_q[1] && !rbk_q[1]) rsp_rdata <= ReadData;
      if (READBACK && iss_q[1] && rbk_q[1] && (ReadData != rb_data_q)) wr_err <= 1'b1;
      busy        <= (state_d != S_IDLE);
      cmd_ready   <= (state_d == S_IDLE);
      wdata_ready <= (state_d == S_WRITE) && !rb_pend_d;
    end
  end

endmodule

// File: tb/tb_apb_bus_master.sv
// Self-checking bench for apb_bus_master: per-cycle vector tables for write/read bursts,
// hand-written sequences for address wrap, mid-burst reset and (when enabled) readback.
`timescale 1ns/1ps

module tb_apb_bus_master;

  localparam int AW = 13;
  localparam int DW = 24;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy, wr_err;
  logic [1:0]    control;
  logic [AW-1:0] address;
  logic [DW-1:0] WriteData, ReadData;

  int total = 0;
  int bad   = 0;

  apb_bus_master #(.AMBA_WORD(DW), .AMBA_ADDR_DEPTH(AW-1)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .wr_err(wr_err),
    .control(control), .address(address), .WriteData(WriteData), .ReadData(ReadData)
  );

  always #5 clock = ~clock;

  // Register bank model: one-cycle registered read; address 0x005 corrupted in readback builds.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] bank_rd;
  always @(posedge clock) begin
    if (reset) bank_rd <= '0;
    else if (control == 2'b10) begin
`ifdef APB_MASTER_READBACK_EN
      if (address == 13'h005) bank_rd <= mem[address] ^ 24'h000001;
      else bank_rd <= mem[address];
`else
      bank_rd <= mem[address];
`endif
    end
    if (control == 2'b01) mem[address] <= WriteData;
  end
  assign ReadData = bank_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          cv, cw;
    logic [AW-1:0] ca;
    logic [3:0]    cl;
    logic          wv;
    logic [DW-1:0] wd;
    logic [1:0]    e_ctl;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic          e_cr, e_wr, e_busy;
  } vec_t;

  vec_t wr_tbl [7];
  vec_t rd_tbl [9];
  logic [DW-1:0] wbuf [16];

  task automatic run_vec(input string tag, input vec_t v);
    check({tag, "_control"},     32'(control),     32'(v.e_ctl));
    check({tag, "_address"},     32'(address),     32'(v.e_addr));
    check({tag, "_WriteData"},   32'(WriteData),   32'(v.e_wd));
    check({tag, "_rsp_valid"},   32'(rsp_valid),   32'(v.e_rv));
    check({tag, "_rsp_rdata"},   32'(rsp_rdata),   32'(v.e_rd));
    check({tag, "_cmd_ready"},   32'(cmd_ready),   32'(v.e_cr));
    check({tag, "_wdata_ready"}, 32'(wdata_ready), 32'(v.e_wr));
    check({tag, "_busy"},        32'(busy),        32'(v.e_busy));
    cmd_valid = v.cv; cmd_write = v.cw; cmd_addr = v.ca; cmd_len = v.cl;
    wdata_valid = v.wv; wdata = v.wd;
    @(negedge clock);
  endtask

  task automatic wait_cmd_ready(input string tag);
    int t = 0;
    while (!cmd_ready && t < 60) begin
      @(negedge clock);
      t++;
    end
    check({tag, "_cmd_ready_wait"}, 32'(cmd_ready), 32'd1);
  endtask

  // Handshake-driven write burst; data comes from wbuf.
  task automatic write_burst(input logic [AW-1:0] a, input logic [3:0] len);
    int i = 0;
    int t = 0;
    wait_cmd_ready("wb_start");
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len;
    @(negedge clock);
    cmd_valid = 1'b0;
    while (i <= int'(len) && t < 100) begin
      if (wdata_ready) begin
        wdata_valid = 1'b1;
        wdata = wbuf[i];
        i++;
      end else begin
        wdata_valid = 1'b0;
      end
      @(negedge clock);
      t++;
    end
    wdata_valid = 1'b0;
    check("wb_beats_sent", 32'(i), 32'(int'(len) + 1));
    wait_cmd_ready("wb_end");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] addr_q [$];
    logic [DW-1:0] data_q [$];
    int issues, t, rv_seen, bus_seen;

    //          cv    cw    addr      len   wv    wdata        ctl    e_addr    e_wd         rv    e_rd         cr    wr    busy
    wr_tbl[0] = '{1'b1, 1'b1, 13'h010, 4'd3, 1'b0, 24'h000000, 2'b00, 13'h000, 24'h000000, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    wr_tbl[1] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b1, 24'h111111, 2'b00, 13'h000, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1};
    wr_tbl[2] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b1, 24'h222222, 2'b01, 13'h010, 24'h111111, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1};
    wr_tbl[3] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b1, 24'h333333, 2'b01, 13'h011, 24'h222222, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1};
    wr_tbl[4] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b1, 24'h444444, 2'b01, 13'h012, 24'h333333, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1};
    wr_tbl[5] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b1, 24'h999999, 2'b01, 13'h013, 24'h444444, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    wr_tbl[6] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b0, 24'h000000, 2'b00, 13'h013, 24'h444444, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};

    rd_tbl[0] = '{1'b1, 1'b0, 13'h010, 4'd3, 1'b0, 24'h000000, 2'b00, 13'h013, 24'h444444, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    rd_tbl[1] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b1, 24'h777777, 2'b00, 13'h013, 24'h444444, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1};
    rd_tbl[2] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b1, 24'h777777, 2'b10, 13'h010, 24'h444444, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1};
    rd_tbl[3] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b1, 24'h777777, 2'b10, 13'h011, 24'h444444, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1};
    rd_tbl[4] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b1, 24'h777777, 2'b10, 13'h012, 24'h444444, 1'b1, 24'h111111, 1'b0, 1'b0, 1'b1};
    rd_tbl[5] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b1, 24'h777777, 2'b10, 13'h013, 24'h444444, 1'b1, 24'h222222, 1'b0, 1'b0, 1'b1};
    rd_tbl[6] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b1, 24'h777777, 2'b00, 13'h013, 24'h444444, 1'b1, 24'h333333, 1'b0, 1'b0, 1'b1};
    rd_tbl[7] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b1, 24'h777777, 2'b00, 13'h013, 24'h444444, 1'b1, 24'h444444, 1'b0, 1'b0, 1'b1};
    rd_tbl[8] = '{1'b0, 1'b0, 13'h000, 4'd0, 1'b0, 24'h000000, 2'b00, 13'h013, 24'h444444, 1'b0, 24'h444444, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0;

    // Reset for 3 cycles, then release
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_control",     32'(control),     32'd0);
    check("rst_address",     32'(address),     32'd0);
    check("rst_WriteData",   32'(WriteData),   32'd0);
    check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    check("rst_rsp_rdata",   32'(rsp_rdata),   32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_wr_err",      32'(wr_err),      32'd0);
    check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    check("rst_cmd_ready",   32'(cmd_ready),   32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_control",   32'(control),   32'd0);
    check("post_rst_busy",      32'(busy),      32'd0);

    // 4-beat write burst to 0x010
`ifdef APB_MASTER_READBACK_EN
    wbuf[0] = 24'h111111; wbuf[1] = 24'h222222; wbuf[2] = 24'h333333; wbuf[3] = 24'h444444;
    write_burst(13'h010, 4'd3);
    check("rb_clean_wr_err", 32'(wr_err), 32'd0);
`else
    for (int i = 0; i < 7; i++) run_vec($sformatf("wr%0d", i), wr_tbl[i]);
`endif

    // 4-beat read burst back from 0x010
    for (int i = 0; i < 9; i++) run_vec($sformatf("rd%0d", i), rd_tbl[i]);

    // Address wrap on write and on read
    wbuf[0] = 24'hAAAAAA; wbuf[1] = 24'h5A5A5A;
    write_burst(13'h1FFF, 4'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h1FFF; cmd_len = 4'd1;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (control == 2'b10) addr_q.push_back(address);
      if (rsp_valid) data_q.push_back(rsp_rdata);
      @(negedge clock);
    end
    check("wrap_issue_count", 32'(addr_q.size()), 32'd2);
    check("wrap_rsp_count",   32'(data_q.size()), 32'd2);
    if (addr_q.size() == 2) begin
      check("wrap_addr0", 32'(addr_q[0]), 32'h1FFF);
      check("wrap_addr1", 32'(addr_q[1]), 32'h0000);
    end
    if (data_q.size() == 2) begin
      check("wrap_data0", 32'(data_q[0]), 32'hAAAAAA);
      check("wrap_data1", 32'(data_q[1]), 32'h5A5A5A);
    end
    check("wrap_cmd_ready", 32'(cmd_ready), 32'd1);
`ifndef APB_MASTER_READBACK_EN
    check("no_rb_wr_err", 32'(wr_err), 32'd0);
`endif

    // Reset in the middle of a 16-beat read, right after the 5th issue cycle
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h100; cmd_len = 4'd15;
    @(negedge clock);
    cmd_valid = 1'b0;
    issues = 0;
    t = 0;
    while (t < 40) begin
      if (control == 2'b10) issues++;
      if (issues == 5) break;
      @(negedge clock);
      t++;
    end
    check("midrst_issues", 32'(issues), 32'd5);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_control",   32'(control),   32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    rv_seen = 0;
    bus_seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (rsp_valid) rv_seen++;
      if (control != 2'b00) bus_seen++;
    end
    check("midrst_late_rsp", 32'(rv_seen),   32'd0);
    check("midrst_late_bus", 32'(bus_seen),  32'd0);
    check("midrst_idle",     32'(cmd_ready), 32'd1);

`ifdef APB_MASTER_READBACK_EN
    // Readback to the corrupted address sets the sticky error flag
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'h005; cmd_len = 4'd0;
    @(negedge clock);
    cmd_valid = 1'b0;
    check("rb_wdata_ready", 32'(wdata_ready), 32'd1);
    wdata_valid = 1'b1; wdata = 24'hABCDEF;
    @(negedge clock);
    wdata_valid = 1'b0;
    check("rb_wr_control", 32'(control), 32'd1);
    check("rb_wr_address", 32'(address), 32'h005);
    @(negedge clock);
    check("rb_rd_control", 32'(control), 32'd2);
    check("rb_rd_address", 32'(address), 32'h005);
    check("rb_rd_rsp",     32'(rsp_valid), 32'd0);
    @(negedge clock);
    check("rb_err_early", 32'(wr_err), 32'd0);
    check("rb_no_rsp",    32'(rsp_valid), 32'd0);
    @(negedge clock);
    check("rb_err_set", 32'(wr_err), 32'd1);
    wbuf[0] = 24'h123456;
    write_burst(13'h006, 4'd0);
    check("rb_err_sticky", 32'(wr_err), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
